// File: rtl/hsiao_64_pkg.sv
// hsiao_64_pkg: Hsiao (72,64) SEC-DED code constants shared by encoder and decoder.
// H_COL[i] is column i of H; element j of a column is H[j][i], the c_j contribution of data bit i.
package hsiao_64_pkg;
    localparam int DATA_W = 64;
    localparam int CHK_W = 8;
    localparam int CODE_W = 72;
    // 56 weight-3 columns in lexicographic order, then 8 weight-5 columns
    localparam logic [0:CHK_W-1] H_COL [0:DATA_W-1] = '{
        8'b11100000, 8'b11010000, 8'b11001000, 8'b11000100, 8'b11000010, 8'b11000001,
        8'b10110000, 8'b10101000, 8'b10100100, 8'b10100010, 8'b10100001,
        8'b10011000, 8'b10010100, 8'b10010010, 8'b10010001,
        8'b10001100, 8'b10001010, 8'b10001001, 8'b10000110, 8'b10000101, 8'b10000011,
        8'b01110000, 8'b01101000, 8'b01100100, 8'b01100010, 8'b01100001,
        8'b01011000, 8'b01010100, 8'b01010010, 8'b01010001,
        8'b01001100, 8'b01001010, 8'b01001001, 8'b01000110, 8'b01000101, 8'b01000011,
        8'b00111000, 8'b00110100, 8'b00110010, 8'b00110001,
        8'b00101100, 8'b00101010, 8'b00101001, 8'b00100110, 8'b00100101, 8'b00100011,
        8'b00011100, 8'b00011010, 8'b00011001, 8'b00010110, 8'b00010101, 8'b00010011,
        8'b00001110, 8'b00001101, 8'b00001011, 8'b00000111,
        8'b11111000, 8'b01111100, 8'b00111110, 8'b00011111,
        8'b10001111, 8'b11000111, 8'b11100011, 8'b11110001
    };
endpackage

// File: rtl/hsiao_64_par32.sv
// hsiao_64_par32: combinational partial check bits for one 32-bit half of the data word.
// BASE selects which half of H the data bits map onto (0 or 32).
module hsiao_64_par32
    import hsiao_64_pkg::*;
#(
    parameter int BASE = 0
) (
    input  logic [0:31]      data,
    output logic [0:CHK_W-1] par
);
    always_comb begin
        par = '0;
        for (int i = 0; i < 32; i++) par ^= data[i] ? H_COL[BASE + i] : '0;
    end
endmodule

// File: rtl/hsiao_64_enc_pipe.sv
// hsiao_64_enc_pipe: 2-stage valid/ready Hsiao (72,64) encoder with delivered-word counter.
// Define HSIAO_ERR_INJECT_EN to add one-shot armed error injection into a chosen codeword.
module hsiao_64_enc_pipe
    import hsiao_64_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [0:DATA_W-1]   i_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [0:CODE_W-1]   o_code,
    output logic [CNT_W-1:0]    o_word_cnt
`ifdef HSIAO_ERR_INJECT_EN
    ,
    input  logic                i_inj_arm,
    input  logic [0:CODE_W-1]   i_inj_mask,
    output logic                o_inj_done
`endif
);
    logic s1_valid, s1_adv, s2_adv, in_xfer, out_xfer;
    logic [0:DATA_W-1] s1_data;
    logic [0:CHK_W-1] plo, phi, s1_plo, s1_phi;
    logic [0:CODE_W-1] s1_mask;
    assign s2_adv = !o_valid || i_ready;
    assign s1_adv = !s1_valid || s2_adv;
    assign o_ready = s1_adv && !reset;
    assign in_xfer = i_valid && o_ready;
    assign out_xfer = o_valid && i_ready;
    hsiao_64_par32 #(.BASE(0)) u_par_lo (.data(i_data[0:31]), .par(plo));
    hsiao_64_par32 #(.BASE(32)) u_par_hi (.data(i_data[32:63]), .par(phi));
`ifdef HSIAO_ERR_INJECT_EN
    logic armed, inj_hit, s1_tag, s2_tag;
    logic [0:CODE_W-1] arm_mask, inj_mask;
    // a same-cycle arm takes precedence so the accepted word gets the newest mask
    assign inj_hit = i_inj_arm || armed;
    assign inj_mask = i_inj_arm ? i_inj_mask : arm_mask;
    assign o_inj_done = !reset && out_xfer && s2_tag;
    always_ff @(posedge clk) begin
        if (reset) begin
            armed <= 1'b0;
            s1_tag <= 1'b0;
            s2_tag <= 1'b0;
            s1_mask <= '0;
        end else begin
            armed <= in_xfer ? 1'b0 : (i_inj_arm || armed);
            if (i_inj_arm) arm_mask <= i_inj_mask;
            if (s1_adv) s1_tag <= i_valid && inj_hit;
            if (in_xfer) s1_mask <= inj_hit ? inj_mask : '0;
            if (s2_adv) s2_tag <= s1_valid && s1_tag;
        end
    end
`else
    assign s1_mask = '0;
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            o_valid <= 1'b0;
            o_code <= '0;
            o_word_cnt <= '0;
        end else begin
            if (s1_adv) s1_valid <= i_valid;
            if (in_xfer) begin
                s1_data <= i_data;
                s1_plo <= plo;
                s1_phi <= phi;
            end
            if (s2_adv) o_valid <= s1_valid;
            if (s2_adv && s1_valid) o_code <= {s1_data, s1_plo ^ s1_phi} ^ s1_mask;
            if (out_xfer) o_word_cnt <= o_word_cnt + 1'b1;
        end
    end
endmodule
